// File: rtl/vsa_core_hs_if.sv
`default_nettype none
// ============================================================================
// vsa_core_hs_if : instruction/data memory handshake bundle for vsa_core_hs
// Revision 1.0
// ============================================================================
interface vsa_core_hs_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 12
);
  logic [PC_W-1:0]   PC;
  logic              imem_req;
  logic              imem_ack;
  logic [15:0]       instruction;
  logic [DATA_W-1:0] ALUOutput;
  logic              mem_req;
  logic              mem_ack;
  logic              wr;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              halted;

  modport master (
    output PC, imem_req, ALUOutput, mem_req, wr, dataout, halted,
    input  imem_ack, instruction, mem_ack, datain
  );

  modport slave (
    input  PC, imem_req, ALUOutput, mem_req, wr, dataout, halted,
    output imem_ack, instruction, mem_ack, datain
  );
endinterface
`default_nettype wire

// File: rtl/vsa_core_hs.sv
`default_nettype none
// ============================================================================
// vsa_core_hs : multi-cycle 16-bit VSA core with req/ack memory handshakes
// Revision 1.0
// ============================================================================
module vsa_core_hs #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 12
) (
  input  wire logic      clock,
  input  wire logic      reset,
  vsa_core_hs_if.master  bus
);
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_BEQZ = 3'd2;
  localparam logic [2:0] OP_ALU  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SUBI = 3'd5;
  localparam logic [2:0] OP_BNEZ = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_npc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_lmd;
  logic              r_cond;
  logic [DATA_W-1:0] r_rf [1:3];

  // Instruction bit 0 is the MSB, so field [0:2] maps to r_ir[15:13] etc.
  logic [2:0]        w_op;
  logic [1:0]        w_rs1;
  logic [1:0]        w_rs2;
  logic [1:0]        w_rd;
  logic [6:0]        w_fn;
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_br_off;
  logic [PC_W-1:0]   w_br_tgt;
  logic              w_is_mem;
  logic              w_is_br;
  logic              w_stop;
  logic [DATA_W-1:0] w_a_rd;
  logic [DATA_W-1:0] w_b_rd;
  logic [DATA_W-1:0] w_alu_res;
  logic [1:0]        w_dest;
  logic              w_wb_en;

  assign w_op     = r_ir[15:13];
  assign w_rs1    = r_ir[12:11];
  assign w_rs2    = r_ir[10:9];
  assign w_rd     = r_ir[8:7];
  assign w_fn     = r_ir[6:0];
  assign w_imm    = DATA_W'($signed(r_ir[8:0]));
  assign w_br_off = PC_W'($signed(r_ir[8:0]));
  assign w_br_tgt = r_npc + (w_br_off << 1);
  assign w_is_mem = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_is_br  = (w_op == OP_BEQZ) || (w_op == OP_BNEZ);
  assign w_stop   = (w_op == OP_HALT) || ((w_op == OP_ALU) && (w_fn >= 7'd7));
  assign w_dest   = (w_op == OP_ALU) ? w_rd : w_rs2;
  assign w_wb_en  = (w_dest != 2'd0) &&
                    ((w_op == OP_ALU) || (w_op == OP_ADDI) ||
                     (w_op == OP_SUBI) || (w_op == OP_LW));

  always_comb begin
    w_a_rd = '0;
    w_b_rd = '0;
    if (w_rs1 != 2'd0) w_a_rd = r_rf[w_rs1];
    if (w_rs2 != 2'd0) w_b_rd = r_rf[w_rs2];
  end

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_LW, OP_SW, OP_ADDI: w_alu_res = r_a + w_imm;
      OP_SUBI:               w_alu_res = r_a - w_imm;
      OP_BEQZ, OP_BNEZ:      w_alu_res = DATA_W'(w_br_tgt);
      OP_ALU: begin
        case (w_fn)
          7'd0:    w_alu_res = r_a + r_b;
          7'd1:    w_alu_res = r_a - r_b;
          7'd2:    w_alu_res = r_a & r_b;
          7'd3:    w_alu_res = r_a | r_b;
          7'd4:    w_alu_res = r_a ^ r_b;
          7'd5:    w_alu_res = r_a >> 1;
          7'd6:    w_alu_res = r_a << 1;
          default: w_alu_res = '0;
        endcase
      end
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IF;
      r_pc    <= '0;
      r_npc   <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_lmd   <= '0;
      r_cond  <= 1'b0;
      for (int i = 1; i <= 3; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_IF: begin
          if (bus.imem_ack) begin
            r_ir    <= bus.instruction;
            r_npc   <= r_pc + PC_W'(2);
            r_state <= S_ID;
          end
        end
        S_ID: begin
          r_a     <= w_a_rd;
          r_b     <= w_b_rd;
          r_state <= S_EX;
        end
        S_EX: begin
          if (w_stop) begin
            r_state <= S_HALT;
          end else begin
            r_alu <= w_alu_res;
            if (w_is_br) r_cond <= (w_op == OP_BEQZ) ? (r_a == '0) : (r_a != '0);
            r_state <= S_MEM;
          end
        end
        S_MEM: begin
          // Non-memory ops pass straight through; LW/SW wait for the ack.
          if (!w_is_mem || bus.mem_ack) begin
            if (w_op == OP_LW) r_lmd <= bus.datain;
            r_pc    <= (w_is_br && r_cond) ? PC_W'(r_alu) : r_npc;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (w_wb_en) r_rf[w_dest] <= (w_op == OP_LW) ? r_lmd : r_alu;
          r_state <= S_IF;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IF;
      endcase
    end
  end

  assign bus.PC        = r_pc;
  assign bus.imem_req  = (r_state == S_IF);
  assign bus.mem_req   = (r_state == S_MEM) && w_is_mem;
  assign bus.wr        = (r_state == S_MEM) && (w_op == OP_SW);
  assign bus.ALUOutput = r_alu;
  assign bus.dataout   = r_b;
  assign bus.halted    = (r_state == S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_vsa_core_hs.sv
`default_nettype none
// Bench for vsa_core_hs: an ISA-level model fills a scoreboard of expected
// fetches (PC, cycle) and data accesses, checked as the memory responder grants them.
module tb_vsa_core_hs;
  localparam int DATA_W = 16;
  localparam int PC_W   = 12;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_BEQZ = 3'd2;
  localparam logic [2:0] OP_ALU  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SUBI = 3'd5;
  localparam logic [2:0] OP_BNEZ = 3'd6;

  typedef struct {
    logic [11:0] pc;
    int          cyc;
  } fetch_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vsa_core_hs_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  vsa_core_hs #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] imem [0:2047];
  logic [15:0] ld_val;
  int          wi, wm;
  int          cyc;
  int          n_checks, n_fail;
  int          icnt, mcnt;
  fetch_t      q_fetch [$];
  mem_t        q_mem [$];
  fetch_t      rsp_f;
  mem_t        rsp_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Memory responder: decides acks at negedge, checked against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      bus.imem_ack    = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.instruction = 16'($urandom);
      bus.datain      = 16'($urandom);
      icnt = 0;
      mcnt = 0;
    end else begin
      if (bus.imem_req && q_fetch.size() > 0) begin
        if (icnt == wi) begin
          rsp_f = q_fetch.pop_front();
          check("fetch_pc", 32'(bus.PC), 32'(rsp_f.pc));
          check("fetch_cycle", cyc, rsp_f.cyc);
          bus.instruction = imem[bus.PC[11:1]];
          bus.imem_ack    = 1'b1;
          icnt = 0;
        end else begin
          bus.instruction = 16'($urandom);
          bus.imem_ack    = 1'b0;
          icnt++;
        end
      end else begin
        bus.imem_ack    = bus.imem_req ? 1'b0 : 1'($urandom_range(0, 1));
        bus.instruction = 16'($urandom);
        icnt = 0;
      end

      if (bus.mem_req) begin
        if (mcnt == wm) begin
          check("mem_expected", 32'(q_mem.size() > 0), 32'd1);
          if (q_mem.size() > 0) begin
            rsp_m = q_mem.pop_front();
            check("mem_wr", 32'(bus.wr), 32'(rsp_m.wr));
            check("mem_addr", 32'(bus.ALUOutput), 32'(rsp_m.addr));
            if (rsp_m.wr) check("mem_wdata", 32'(bus.dataout), 32'(rsp_m.data));
          end
          bus.mem_ack = 1'b1;
          bus.datain  = ld_val;
          mcnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          bus.datain  = 16'($urandom);
          mcnt++;
        end
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
        bus.datain  = 16'($urandom);
        mcnt = 0;
      end
    end
  end

  function automatic logic [15:0] ei(input logic [2:0] op, input logic [1:0] rs1,
                                     input logic [1:0] r2, input int imm);
    return {op, rs1, r2, 9'(imm)};
  endfunction

  function automatic logic [15:0] er(input logic [1:0] rs1, input logic [1:0] rs2,
                                     input logic [1:0] rd, input int fn);
    return {OP_ALU, rs1, rs2, rd, 7'(fn)};
  endfunction

  task automatic put(input int addr, input logic [15:0] w);
    imem[addr >> 1] = w;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 2048; i++) imem[i] = 16'hE000;
  endtask

  // Architectural reference: executes the program and queues expected events.
  task automatic model_run(input int max_instr, output logic halts, output logic [11:0] end_pc);
    logic [15:0] r [0:3];
    logic [11:0] pc, npc, tgt;
    logic [15:0] ir, a, b, imm, res;
    logic [2:0]  op;
    logic [1:0]  rs1, rs2, rd;
    logic [6:0]  fn;
    int          s;
    fetch_t      f;
    mem_t        m;
    for (int i = 0; i < 4; i++) r[i] = '0;
    pc = '0;
    s = 0;
    halts = 1'b0;
    for (int k = 0; k < max_instr && !halts; k++) begin
      ir = imem[pc[11:1]];
      {op, rs1, rs2, rd, fn} = ir;
      imm = {{7{ir[8]}}, ir[8:0]};
      a   = r[rs1];
      b   = r[rs2];
      npc = pc + 12'd2;
      tgt = npc + {imm[10:0], 1'b0};
      f.pc = pc;
      f.cyc = s + wi;
      q_fetch.push_back(f);
      s = s + wi + 5;
      case (op)
        OP_LW: begin
          m = '{1'b0, a + imm, 16'h0};
          q_mem.push_back(m);
          s = s + wm;
          if (rs2 != 2'd0) r[rs2] = ld_val;
          pc = npc;
        end
        OP_SW: begin
          m = '{1'b1, a + imm, b};
          q_mem.push_back(m);
          s = s + wm;
          pc = npc;
        end
        OP_BEQZ: pc = (a == 16'd0) ? tgt : npc;
        OP_BNEZ: pc = (a != 16'd0) ? tgt : npc;
        OP_ALU: begin
          if (fn >= 7'd7) begin
            halts = 1'b1;
          end else begin
            case (fn)
              7'd0:    res = a + b;
              7'd1:    res = a - b;
              7'd2:    res = a & b;
              7'd3:    res = a | b;
              7'd4:    res = a ^ b;
              7'd5:    res = {1'b0, a[15:1]};
              default: res = {a[14:0], 1'b0};
            endcase
            if (rd != 2'd0) r[rd] = res;
            pc = npc;
          end
        end
        OP_ADDI: begin
          if (rs2 != 2'd0) r[rs2] = a + imm;
          pc = npc;
        end
        OP_SUBI: begin
          if (rs2 != 2'd0) r[rs2] = a - imm;
          pc = npc;
        end
        default: halts = 1'b1;
      endcase
    end
    end_pc = pc;
  endtask

  task automatic run_prog(input string name, input int max_instr);
    logic        halts;
    logic [11:0] end_pc;
    int          guard;
    @(negedge clock);
    reset = 1'b1;
    q_fetch.delete();
    q_mem.delete();
    model_run(max_instr, halts, end_pc);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    guard = 0;
    while ((q_fetch.size() > 0 || q_mem.size() > 0) && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    check({name, "_done_in_budget"}, 32'(guard < 3000), 32'd1);
    repeat (10) @(negedge clock);
    check({name, "_halted"}, 32'(bus.halted), 32'(halts));
    check({name, "_end_pc"}, 32'(bus.PC), 32'(end_pc));
    check({name, "_imem_req"}, 32'(bus.imem_req), 32'(!halts));
    check({name, "_mem_req_idle"}, 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    int          guard;
    logic        h;
    logic [11:0] p;
    int          a;
    n_checks = 0;
    n_fail   = 0;
    wi = 0;
    wm = 0;
    ld_val = 16'h0;

    // Immediate ops, stores, negative immediates.
    clear_imem();
    put(0,  ei(OP_ADDI, 0, 1, 5));
    put(2,  ei(OP_SW,   0, 1, 0));
    put(4,  ei(OP_ADDI, 1, 2, -3));
    put(6,  ei(OP_SUBI, 2, 3, -4));
    put(8,  ei(OP_SW,   2, 3, 9));
    put(10, ei(OP_SW,   0, 0, 3));
    put(12, ei(OP_SW,   2, 3, -1));
    run_prog("basic", 50);

    // Reset values of every output.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_pc", 32'(bus.PC), 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_wr", 32'(bus.wr), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_aluout", 32'(bus.ALUOutput), 32'd0);
    check("rst_dataout", 32'(bus.dataout), 32'd0);

    // Load with data wait states, then with fetch wait states too.
    clear_imem();
    put(0, ei(OP_ADDI, 0, 1, 8));
    put(2, ei(OP_LW,   1, 2, 4));
    put(4, ei(OP_SW,   0, 2, 32));
    ld_val = 16'hBEEF;
    wm = 3;
    run_prog("lw_wait", 50);
    wi = 2;
    run_prog("lw_iwait", 50);
    wi = 0;
    wm = 0;

    // Branches: forward taken, not-taken BNEZ, backward loop, self loop.
    clear_imem();
    put(8'h00, ei(OP_ADDI, 0, 1, 3));
    put(8'h02, ei(OP_BEQZ, 0, 0, 6));
    put(8'h10, ei(OP_BNEZ, 0, 0, -1));
    put(8'h12, ei(OP_SUBI, 1, 1, 1));
    put(8'h14, ei(OP_BNEZ, 1, 0, -2));
    put(8'h16, ei(OP_BEQZ, 0, 0, -1));
    run_prog("branch", 12);

    // Register ALU functions, R0 destination, illegal function halts.
    clear_imem();
    ld_val = 16'h8001;
    put(0, ei(OP_LW,   0, 1, 0));
    put(2, ei(OP_ADDI, 0, 2, 16'hF3));
    a = 4;
    for (int fn = 0; fn < 7; fn++) begin
      put(a, er(1, 2, 3, fn));
      put(a + 2, ei(OP_SW, 0, 3, fn));
      a = a + 4;
    end
    put(a,     er(1, 1, 0, 0));
    put(a + 2, ei(OP_SW, 0, 0, 7));
    put(a + 4, er(1, 2, 3, 9));
    run_prog("alu", 50);

    // PC wrap from the top of the address space.
    clear_imem();
    put(0,      ei(OP_BEQZ, 0, 0, -2));
    put(12'hFFE, ei(OP_ADDI, 0, 1, 1));
    run_prog("wrap", 4);

    // Reset in the middle of a store handshake.
    clear_imem();
    put(0, ei(OP_ADDI, 0, 1, 3));
    put(2, ei(OP_SW,   0, 1, 4));
    wm = 1000;
    @(negedge clock);
    reset = 1'b1;
    q_fetch.delete();
    q_mem.delete();
    model_run(2, h, p);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    guard = 0;
    while (!bus.mem_req && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("rstsw_mem_req_seen", 32'(bus.mem_req), 32'd1);
    check("rstsw_wr_seen", 32'(bus.wr), 32'd1);
    check("rstsw_pc_before", 32'(bus.PC), 32'd2);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rstsw_mem_req", 32'(bus.mem_req), 32'd0);
    check("rstsw_wr", 32'(bus.wr), 32'd0);
    check("rstsw_pc", 32'(bus.PC), 32'd0);
    check("rstsw_imem_req", 32'(bus.imem_req), 32'd1);
    wm = 0;

    // Random programs with random wait states.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 2048; i++) imem[i] = 16'($urandom);
      wi = $urandom_range(0, 2);
      wm = $urandom_range(0, 2);
      ld_val = 16'($urandom);
      run_prog("random", 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
